// File: rtl/ysyx_23060187_mem_arbiter_pkg.sv
// ============================================================================
// Module : ysyx_23060187_mem_arbiter_pkg
// Brief  : Shared bus definitions for the IFU/LSU memory arbiter.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

package ysyx_23060187_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam int   MASK_W  = 4;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060187_timeout_cnt.sv
// ============================================================================
// Module : ysyx_23060187_timeout_cnt
// Brief  : Watchdog counter; expires once TIMEOUT_CYCLES busy cycles elapsed.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The owner leaves REQ/RSP on expiry, so the count never needs to saturate.
  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/ysyx_23060187_mem_arbiter.sv
// ============================================================================
// Module : ysyx_23060187_mem_arbiter
// Brief  : Single-outstanding IFU/LSU arbiter for one memory port, LSU first.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_mem_arbiter
  import ysyx_23060187_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              owner;
  logic              idle;
  logic              busy;
  logic              accept;
  logic              done;
  logic              expired;
  logic              timeout;
  logic              finish;
  logic [DATA_W-1:0] rsp_data;

  // Everything visible is gated by rst so a reset cycle never emits a pulse.
  assign idle          = (state == IDLE) && !rst;
  assign busy          = (state == REQ) || (state == RSP);
  assign lsu_req_ready = idle && lsu_req_valid;
  assign ifu_req_ready = idle && ifu_req_valid && !lsu_req_valid;
  assign accept        = lsu_req_ready || ifu_req_ready;

  assign done     = (state == RSP) && mem_rsp_valid && !rst;
  assign timeout  = expired && !done && !rst;
  assign finish   = done || timeout;
  assign rsp_data = (done && !mem_wen) ? mem_rdata : '0;

  assign mem_req_valid = (state == REQ) && !expired && !rst;

  assign ifu_rsp_valid = finish && (owner == OWN_IFU);
  assign ifu_rsp_err   = timeout && (owner == OWN_IFU);
  assign ifu_rdata     = (owner == OWN_IFU) ? rsp_data : '0;
  assign lsu_rsp_valid = finish && (owner == OWN_LSU);
  assign lsu_rsp_err   = timeout && (owner == OWN_LSU);
  assign lsu_rdata     = (owner == OWN_LSU) ? rsp_data : '0;

  ysyx_23060187_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IFU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= REQ;
            if (lsu_req_valid) begin
              owner     <= OWN_LSU;
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wen ? lsu_wmask : '0;
            end else begin
              owner     <= OWN_IFU;
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (expired) begin
            state <= IDLE;
          end else if (mem_req_ready) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid || expired) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
